ft_sram_loader: RTL and testbench

//  Parametrised FT240X-to-SRAM loader/readback engine for the ROM emulator. Decodes host

---
 rtl/ft_sram_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_ft_sram_loader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_sram_loader.sv
// FT240X-to-SRAM loader/readback engine: host command decode, SRAM word writes,
// word readback to the host, and SRAM ownership mux between loader and target.
module ft_sram_loader #(
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_BYTES = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                    clk24MHz,
    input  logic                    rst,
    input  logic [7:0]              ft_din,
    output logic [7:0]              ft_dout,
    output logic                    ft_doe,
    output logic                    ft_nRD,
    output logic                    ft_nWR,
    input  logic                    ft_RXF,
    input  logic                    ft_TXE,
    input  logic [ADDR_W-1:0]       tgt_addr,
    output logic [ADDR_W-1:0]       sram_addr,
    input  logic [8*DATA_BYTES-1:0] sram_din,
    output logic [8*DATA_BYTES-1:0] sram_dout,
    output logic                    sram_doe,
    output logic                    sram_nWE,
    output logic                    sram_nOE,
    output logic                    mode_run,
    output logic                    busy
);

    localparam int unsigned DATA_W     = 8 * DATA_BYTES;
    localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int unsigned ASH_W      = 8 * ADDR_BYTES;
    localparam int unsigned BCNT_W     = 4;

    typedef enum logic [3:0] {
        S_IDLE, S_RD_WAIT, S_RD_REQ, S_RD_LATCH, S_RD_DONE,
        S_WE_SETUP, S_WE_PULSE, S_WE_HOLD,
        S_OE_1, S_OE_2,
        S_WR_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD
    } state_t;

    // What the byte currently being fetched from the host is for
    typedef enum logic [2:0] {R_CMD, R_ADDR, R_WCNT, R_RCNT, R_DATA} role_t;

    state_t              state, state_nx;
    role_t               role, role_nx;
    logic [7:0]          byte_q, byte_nx;
    logic [BCNT_W-1:0]   bcnt, bcnt_nx;
    logic [CNT_W-1:0]    words, words_nx;
    logic [DATA_W-1:0]   data_q, data_nx;
    logic [ASH_W-1:0]    addr_sh, addr_sh_nx;
    logic [ADDR_W-1:0]   addr_ctr, addr_nx;
    logic                mode_nx;
    logic [7:0]          dout_nx;
    logic                we_n_q, doe_q, oe_q;

    // State and datapath registers; strobes are registered from the next state
    always_ff @(posedge clk24MHz) begin
        if (rst) begin
            state    <= S_IDLE;
            role     <= R_CMD;
            byte_q   <= '0;
            bcnt     <= '0;
            words    <= '0;
            data_q   <= '0;
            addr_sh  <= '0;
            addr_ctr <= '0;
            mode_run <= 1'b0;
            busy     <= 1'b0;
            ft_dout  <= '0;
            ft_doe   <= 1'b0;
            ft_nRD   <= 1'b1;
            ft_nWR   <= 1'b1;
            we_n_q   <= 1'b1;
            doe_q    <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            role     <= role_nx;
            byte_q   <= byte_nx;
            bcnt     <= bcnt_nx;
            words    <= words_nx;
            data_q   <= data_nx;
            addr_sh  <= addr_sh_nx;
            addr_ctr <= addr_nx;
            mode_run <= mode_nx;
            busy     <= (state_nx != S_IDLE);
            ft_dout  <= dout_nx;
            ft_doe   <= (state_nx == S_WR_SETUP) || (state_nx == S_WR_PULSE) ||
                        (state_nx == S_WR_HOLD);
            ft_nRD   <= !((state_nx == S_RD_REQ) || (state_nx == S_RD_LATCH));
            ft_nWR   <= (state_nx != S_WR_PULSE);
            we_n_q   <= (state_nx != S_WE_PULSE);
            doe_q    <= (state_nx == S_WE_SETUP) || (state_nx == S_WE_PULSE) ||
                        (state_nx == S_WE_HOLD);
            oe_q     <= (state_nx == S_OE_1) || (state_nx == S_OE_2);
        end
    end

    // Next-state logic: byte fetch/send handshakes, command decode, burst sequencing
    always_comb begin
        state_nx   = state;
        role_nx    = role;
        byte_nx    = byte_q;
        bcnt_nx    = bcnt;
        words_nx   = words;
        data_nx    = data_q;
        addr_sh_nx = addr_sh;
        addr_nx    = addr_ctr;
        mode_nx    = mode_run;
        dout_nx    = ft_dout;

        case (state)
            S_IDLE: begin
                if (!ft_RXF) begin
                    state_nx = S_RD_REQ;
                    role_nx  = R_CMD;
                end
            end
            S_RD_WAIT:  if (!ft_RXF) state_nx = S_RD_REQ;
            S_RD_REQ:   state_nx = S_RD_LATCH;
            S_RD_LATCH: begin
                byte_nx  = ft_din;
                state_nx = S_RD_DONE;
            end
            S_RD_DONE: begin
                case (role)
                    R_CMD: begin
                        state_nx = S_IDLE;
                        if (byte_q[7:4] == 4'h1) begin
                            mode_nx = byte_q[0];
                        end else if (!mode_run) begin
                            case (byte_q)
                                8'h01: addr_nx = '0;
                                8'h02: begin
                                    role_nx  = R_ADDR;
                                    bcnt_nx  = BCNT_W'(ADDR_BYTES - 1);
                                    state_nx = S_RD_WAIT;
                                end
                                8'h20: begin
                                    role_nx  = R_WCNT;
                                    state_nx = S_RD_WAIT;
                                end
                                8'h30: begin
                                    role_nx  = R_RCNT;
                                    state_nx = S_RD_WAIT;
                                end
                                default: ;
                            endcase
                        end
                    end
                    R_ADDR: begin
                        addr_sh_nx = ASH_W'({addr_sh, byte_q});
                        if (bcnt == '0) begin
                            // Only the low ADDR_W bits of the MSB-first field are kept
                            addr_nx  = ADDR_W'(ASH_W'({addr_sh, byte_q}));
                            state_nx = S_IDLE;
                        end else begin
                            bcnt_nx  = bcnt - 1'b1;
                            state_nx = S_RD_WAIT;
                        end
                    end
                    R_WCNT: begin
                        words_nx = CNT_W'(byte_q);
                        role_nx  = R_DATA;
                        bcnt_nx  = BCNT_W'(DATA_BYTES - 1);
                        state_nx = S_RD_WAIT;
                    end
                    R_RCNT: begin
                        words_nx = CNT_W'(byte_q);
                        state_nx = S_OE_1;
                    end
                    R_DATA: begin
                        data_nx = DATA_W'({data_q, byte_q});
                        if (bcnt == '0) begin
                            state_nx = S_WE_SETUP;
                        end else begin
                            bcnt_nx  = bcnt - 1'b1;
                            state_nx = S_RD_WAIT;
                        end
                    end
                    default: state_nx = S_IDLE;
                endcase
            end
            S_WE_SETUP: state_nx = S_WE_PULSE;
            S_WE_PULSE: state_nx = S_WE_HOLD;
            S_WE_HOLD: begin
                addr_nx = ADDR_W'(addr_ctr + 1'b1);
                if (words == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    words_nx = words - 1'b1;
                    bcnt_nx  = BCNT_W'(DATA_BYTES - 1);
                    state_nx = S_RD_WAIT;
                end
            end
            S_OE_1: state_nx = S_OE_2;
            S_OE_2: begin
                data_nx  = sram_din;
                bcnt_nx  = BCNT_W'(DATA_BYTES - 1);
                state_nx = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!ft_TXE) begin
                    dout_nx  = data_q[DATA_W-1 -: 8];
                    state_nx = S_WR_SETUP;
                end
            end
            S_WR_SETUP: state_nx = S_WR_PULSE;
            S_WR_PULSE: state_nx = S_WR_HOLD;
            S_WR_HOLD: begin
                if (bcnt == '0) begin
                    addr_nx = ADDR_W'(addr_ctr + 1'b1);
                    if (words == '0) begin
                        state_nx = S_IDLE;
                    end else begin
                        words_nx = words - 1'b1;
                        state_nx = S_OE_1;
                    end
                end else begin
                    bcnt_nx  = bcnt - 1'b1;
                    data_nx  = DATA_W'({data_q, 8'h00});
                    state_nx = S_WR_WAIT;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // SRAM ownership mux: the target owns a read-only bus in RUN mode
    always_comb begin
        sram_dout = data_q;
        sram_addr = mode_run ? tgt_addr : addr_ctr;
        sram_nOE  = mode_run ? 1'b0 : !oe_q;
        sram_nWE  = mode_run ? 1'b1 : we_n_q;
        sram_doe  = mode_run ? 1'b0 : doe_q;
    end

endmodule

// File: tb/tb_ft_sram_loader.sv
// Bench for ft_sram_loader: FT240X FIFO and SRAM models, directed corner cases,
// a readback vector table and randomized command streams against a stream-level model.
module tb_ft_sram_loader;

    localparam int unsigned ADDR_W     = 18;
    localparam int unsigned DATA_BYTES = 2;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned DATA_W     = 16;
    localparam int          DEPTH      = 1 << ADDR_W;

    logic              clk24MHz = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        ft_din = 8'h00;
    logic [7:0]        ft_dout;
    logic              ft_doe, ft_nRD, ft_nWR;
    logic              ft_RXF = 1'b1;
    logic              ft_TXE = 1'b0;
    logic [ADDR_W-1:0] tgt_addr = 18'h00155;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din = '0;
    logic [DATA_W-1:0] sram_dout;
    logic              sram_doe, sram_nWE, sram_nOE, mode_run, busy;

    ft_sram_loader #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .CNT_W(CNT_W)) dut (
        .clk24MHz(clk24MHz), .rst(rst),
        .ft_din(ft_din), .ft_dout(ft_dout), .ft_doe(ft_doe),
        .ft_nRD(ft_nRD), .ft_nWR(ft_nWR), .ft_RXF(ft_RXF), .ft_TXE(ft_TXE),
        .tgt_addr(tgt_addr), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_nWE(sram_nWE),
        .sram_nOE(sram_nOE), .mode_run(mode_run), .busy(busy)
    );

    always #20 clk24MHz = ~clk24MHz;

    logic [DATA_W-1:0] mem [int];
    logic [DATA_W-1:0] m_mem [int];
    logic [7:0]        rx_q [$];
    logic [7:0]        tx_q [$];
    logic [7:0]        m_tx [$];
    logic [7:0]        s [$];
    int                wr_list [$];
    int                m_addr = 0;
    bit                m_mode = 1'b0;

    bit hold_rxf = 1'b0, hold_txe = 1'b0, rand_stall = 1'b0;
    bit stall_rxf, stall_txe;
    int n_checks = 0, n_pass = 0;
    int we_cnt = 0, rd_samples = 0, wr_samples = 0;
    int rd_low = 0, wr_low = 0, we_low = 0;
    int viol_rd = 0, viol_wr = 0, viol_we = 0, viol_bus = 0;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        return DATA_W'(a * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return init_word(a);
    endfunction

    function automatic logic [DATA_W-1:0] m_rd(input int a);
        if (m_mem.exists(a)) return m_mem[a];
        return init_word(a);
    endfunction

    // FIFO/SRAM models and protocol monitors, all sampled mid-cycle
    always @(negedge clk24MHz) begin
        if (!sram_nWE) begin
            we_cnt++;
            if (!sram_doe) viol_bus++;
            mem[int'(sram_addr)] = sram_dout;
        end
        if (sram_doe && !sram_nOE) viol_bus++;
        sram_din = mem_rd(int'(sram_addr));

        if (!sram_nWE) we_low++;
        else begin
            if (we_low > 1) viol_we++;
            we_low = 0;
        end

        if (!ft_nRD) begin
            rd_low++;
            rd_samples++;
        end else begin
            if (rd_low != 0) begin
                if (rd_low != 2) viol_rd++;
                if (rx_q.size() > 0) void'(rx_q.pop_front());
            end
            rd_low = 0;
        end

        if (!ft_nWR) begin
            wr_low++;
            wr_samples++;
            if (!ft_doe) viol_wr++;
        end else begin
            if (wr_low != 0) begin
                if (wr_low != 1 || !ft_doe) viol_wr++;
                tx_q.push_back(ft_dout);
            end
            wr_low = 0;
        end

        if (rand_stall) begin
            stall_rxf = ($urandom_range(0, 3) == 0);
            stall_txe = ($urandom_range(0, 2) == 0);
        end else begin
            stall_rxf = 1'b0;
            stall_txe = 1'b0;
        end
        ft_RXF = hold_rxf | stall_rxf | (rx_q.size() == 0);
        ft_TXE = hold_txe | stall_txe;
        ft_din = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk24MHz);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        rx_q.push_back(b);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk24MHz);
            if (rx_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s: idle timeout, rx_q=%0d busy=%0b", name, rx_q.size(), busy);
        end
    endtask

    task automatic wait_rx_empty(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk24MHz);
            if (rx_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s: rx drain timeout, rx_q=%0d", name, rx_q.size());
        end
    endtask

    // Stream-level model: applies whole commands to an array memory and address counter
    task automatic model_exec(input logic [7:0] q [$]);
        int i = 0;
        int n;
        logic [7:0] c;
        logic [DATA_W-1:0] w;
        while (i < q.size()) begin
            c = q[i]; i++;
            if (c[7:4] == 4'h1) m_mode = c[0];
            else if (!m_mode) begin
                if (c == 8'h01) m_addr = 0;
                else if (c == 8'h02) begin
                    m_addr = int'({q[i], q[i+1], q[i+2]}) % DEPTH;
                    i += 3;
                end else if (c == 8'h20) begin
                    n = int'(q[i]); i++;
                    for (int k = 0; k <= n; k++) begin
                        w = {q[i], q[i+1]}; i += 2;
                        m_mem[m_addr] = w;
                        wr_list.push_back(m_addr);
                        m_addr = (m_addr + 1) % DEPTH;
                    end
                end else if (c == 8'h30) begin
                    n = int'(q[i]); i++;
                    for (int k = 0; k <= n; k++) begin
                        w = m_rd(m_addr);
                        m_tx.push_back(w[15:8]);
                        m_tx.push_back(w[7:0]);
                        m_addr = (m_addr + 1) % DEPTH;
                    end
                end
            end
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] exp_ctr;
    } vec_t;
    vec_t vecs [5];

    initial begin
        int we0, rd0, wr0, n, rsel;
        bit gen_mode;
        logic [7:0] pick;
        logic [7:0] run_bytes [9];

        vecs[0] = '{18'h00000, 16'hBEEF, 18'h00001};
        vecs[1] = '{18'h3FFFF, 16'h0F0F, 18'h00000};
        vecs[2] = '{18'h00155, 16'h0000, 18'h00156};
        vecs[3] = '{18'h20000, 16'hFFFF, 18'h20001};
        vecs[4] = '{18'h1FFFF, 16'h8001, 18'h20000};
        run_bytes = '{8'h00, 8'h01, 8'h02, 8'h20, 8'h30, 8'h11, 8'h10, 8'h1F, 8'h7E};

        // Reset state
        tick(3);
        check("rst_nRD", 32'(ft_nRD), 1);
        check("rst_nWR", 32'(ft_nWR), 1);
        check("rst_ft_doe", 32'(ft_doe), 0);
        check("rst_ft_dout", 32'(ft_dout), 0);
        check("rst_nWE", 32'(sram_nWE), 1);
        check("rst_sram_doe", 32'(sram_doe), 0);
        check("rst_nOE", 32'(sram_nOE), 1);
        check("rst_mode", 32'(mode_run), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_addr", 32'(sram_addr), 0);
        rst = 1'b0;
        tick(2);

        // Two-word burst write from address 0
        we0 = we_cnt;
        send(8'h20); send(8'h01); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
        wait_idle("t1");
        check("t1_mem0", 32'(mem_rd(0)), 32'h1234);
        check("t1_mem1", 32'(mem_rd(1)), 32'hABCD);
        check("t1_addr", 32'(sram_addr), 2);
        check("t1_we_pulses", 32'(we_cnt - we0), 2);

        // Set address near the top and wrap through all-ones
        send(8'h02); send(8'h03); send(8'hFF); send(8'hFF);
        send(8'h20); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_idle("t2");
        check("t2_mem_top", 32'(mem_rd(32'h3FFFF)), 32'h1122);
        check("t2_mem_wrap", 32'(mem_rd(0)), 32'h3344);
        check("t2_addr", 32'(sram_addr), 1);

        // Readback with TX FIFO full for a while
        send(8'h01); send(8'h20); send(8'h00); send(8'h12); send(8'h34);
        wait_idle("t3a");
        tx_q.delete();
        hold_txe = 1'b1;
        wr0 = wr_samples;
        send(8'h01); send(8'h30); send(8'h00);
        tick(40);
        check("t3_no_nwr_while_full", 32'(wr_samples - wr0), 0);
        check("t3_busy_while_full", 32'(busy), 1);
        hold_txe = 1'b0;
        wait_idle("t3b");
        check("t3_tx_len", 32'(tx_q.size()), 2);
        check("t3_tx0", 32'(tx_q.size() > 0 ? tx_q[0] : 8'h00), 32'h12);
        check("t3_tx1", 32'(tx_q.size() > 1 ? tx_q[1] : 8'h00), 32'h34);
        check("t3_addr", 32'(sram_addr), 1);

        // RUN mode: target owns the bus, loader commands ignored
        send(8'h11);
        wait_idle("t4a");
        check("t4_mode_run", 32'(mode_run), 1);
        check("t4_sram_addr", 32'(sram_addr), 32'h155);
        check("t4_nOE", 32'(sram_nOE), 0);
        check("t4_nWE", 32'(sram_nWE), 1);
        check("t4_doe", 32'(sram_doe), 0);
        we0 = we_cnt;
        send(8'h20);
        wait_idle("t4b");
        check("t4_no_write", 32'(we_cnt - we0), 0);
        check("t4_still_run", 32'(mode_run), 1);
        send(8'h10);
        wait_idle("t4c");
        check("t4_mode_load", 32'(mode_run), 0);
        check("t4_addr_back", 32'(sram_addr), 1);

        // RX FIFO empty between data bytes stalls the burst
        send(8'h02); send(8'h00); send(8'h00); send(8'h40);
        send(8'h20); send(8'h00); send(8'h56);
        wait_rx_empty("t5a");
        hold_rxf = 1'b1;
        send(8'h78);
        rd0 = rd_samples;
        we0 = we_cnt;
        tick(15);
        check("t5_no_nrd_stalled", 32'(rd_samples - rd0), 0);
        check("t5_no_write_stalled", 32'(we_cnt - we0), 0);
        check("t5_busy_stalled", 32'(busy), 1);
        hold_rxf = 1'b0;
        wait_idle("t5b");
        check("t5_mem", 32'(mem_rd(32'h40)), 32'h5678);
        check("t5_one_write", 32'(we_cnt - we0), 1);

        // Readback vector table, address high bits deliberately set
        for (int v = 0; v < 5; v++) begin
            tx_q.delete();
            send(8'h02); send({6'b101011, vecs[v].addr[17:16]});
            send(vecs[v].addr[15:8]); send(vecs[v].addr[7:0]);
            send(8'h20); send(8'h00); send(vecs[v].data[15:8]); send(vecs[v].data[7:0]);
            send(8'h02); send({6'b010100, vecs[v].addr[17:16]});
            send(vecs[v].addr[15:8]); send(vecs[v].addr[7:0]);
            send(8'h30); send(8'h00);
            wait_idle("vec");
            check($sformatf("vec%0d_tx_len", v), 32'(tx_q.size()), 2);
            check($sformatf("vec%0d_tx_msb", v), 32'(tx_q.size() > 0 ? tx_q[0] : 8'h00),
                  32'(vecs[v].data[15:8]));
            check($sformatf("vec%0d_tx_lsb", v), 32'(tx_q.size() > 1 ? tx_q[1] : 8'h00),
                  32'(vecs[v].data[7:0]));
            check($sformatf("vec%0d_addr", v), 32'(sram_addr), 32'(vecs[v].exp_ctr));
        end

        // Reset in the middle of a word: nothing written, state cleared
        send(8'h02); send(8'h00); send(8'h01); send(8'h00);
        wait_idle("t6a");
        check("t6_addr_set", 32'(sram_addr), 32'h100);
        send(8'h20); send(8'h00); send(8'hAB);
        wait_rx_empty("t6b");
        tick(2);
        we0 = we_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 0);
        check("t6_mode", 32'(mode_run), 0);
        check("t6_addr", 32'(sram_addr), 0);
        tick(5);
        check("t6_no_write", 32'(we_cnt - we0), 0);
        check("t6_idle", 32'(busy), 0);

        // Randomized command streams against the model
        foreach (mem[a]) m_mem[a] = mem[a];
        m_addr = 0;
        m_mode = 1'b0;
        for (int b = 0; b < 4; b++) begin
            s.delete(); m_tx.delete(); wr_list.delete(); tx_q.delete();
            gen_mode = 1'b0;
            for (int c = 0; c < 25; c++) begin
                if (gen_mode) begin
                    pick = run_bytes[$urandom_range(0, 8)];
                    if (pick[7:4] == 4'h1) gen_mode = pick[0];
                    s.push_back(pick);
                end else begin
                    rsel = $urandom_range(0, 9);
                    case (rsel)
                        0: s.push_back(8'h00);
                        1: s.push_back(8'h01);
                        2: begin
                            s.push_back(8'h02);
                            if ($urandom_range(0, 1) == 1) begin
                                s.push_back(8'hFF); s.push_back(8'hFF);
                                s.push_back(8'($urandom_range(252, 255)));
                            end else begin
                                s.push_back(8'($urandom)); s.push_back(8'($urandom));
                                s.push_back(8'($urandom));
                            end
                        end
                        3, 4, 5: begin
                            n = $urandom_range(0, 3);
                            s.push_back(8'h20); s.push_back(8'(n));
                            for (int k = 0; k < 2 * (n + 1); k++) s.push_back(8'($urandom));
                        end
                        6, 7: begin
                            s.push_back(8'h30); s.push_back(8'($urandom_range(0, 3)));
                        end
                        8: begin
                            s.push_back(8'h11);
                            gen_mode = 1'b1;
                        end
                        default: s.push_back(8'($urandom_range(64, 255)));
                    endcase
                end
            end
            s.push_back(8'h10);
            model_exec(s);
            rand_stall = (b != 0);
            foreach (s[k]) send(s[k]);
            wait_idle("rnd");
            rand_stall = 1'b0;
            tick(2);
            check($sformatf("rnd%0d_tx_len", b), 32'(tx_q.size()), 32'(m_tx.size()));
            for (int k = 0; k < m_tx.size() && k < tx_q.size(); k++)
                check($sformatf("rnd%0d_tx%0d", b, k), 32'(tx_q[k]), 32'(m_tx[k]));
            foreach (wr_list[k])
                check($sformatf("rnd%0d_mem_%0h", b, wr_list[k]),
                      32'(mem_rd(wr_list[k])), 32'(m_rd(wr_list[k])));
            check($sformatf("rnd%0d_mode", b), 32'(mode_run), 32'(m_mode));
            check($sformatf("rnd%0d_addr", b), 32'(sram_addr), 32'(m_addr));
        end

        // Protocol monitor totals
        check("nrd_pulse_width_errors", 32'(viol_rd), 0);
        check("nwr_pulse_errors", 32'(viol_wr), 0);
        check("nwe_pulse_width_errors", 32'(viol_we), 0);
        check("sram_bus_conflicts", 32'(viol_bus), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
